// File: rtl/eq_ctrl_pkg.sv
// Shared types and helpers for the EQ user-control slice.
// State/menu encodings and the signed saturating gain step used by eq_param_ctrl.
package eq_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int MENU_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_INIT        = 3'd0,
    S_IDLE        = 3'd1,
    S_MENU        = 3'd2,
    S_BAND_SEL    = 3'd3,
    S_SET_GAIN    = 3'd4,
    S_SET_OFFSET  = 3'd5,
    S_WRITE       = 3'd6,
    S_RESET_SWEEP = 3'd7
  } state_t;

  typedef enum logic [MENU_W-1:0] {
    M_EQ     = 2'd0,
    M_OFFSET = 2'd1,
    M_RESET  = 2'd2
  } menu_t;

  // One gain step towards up/down, holding at the inclusive signed limits.
  function automatic int gain_step(input int gain, input logic up,
                                   input int gmin, input int gmax);
    if (up) begin
      return (gain < gmax) ? gain + 1 : gain;
    end
    return (gain > gmin) ? gain - 1 : gain;
  endfunction

endpackage

// File: rtl/eq_write_port.sv
// Gain write port towards the DSP: latches band/gain on a load strobe and
// holds them stable under o_valid until the DSP takes them with i_ready.
// o_done is high in the cycle the transfer happens.
module eq_write_port #(
  parameter int BAND_W = 3,
  parameter int GAIN_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [BAND_W-1:0]        i_band,
  input  logic signed [GAIN_W-1:0] i_gain,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [BAND_W-1:0]        o_band,
  output logic signed [GAIN_W-1:0] o_gain,
  output logic                     o_done
);

  logic                     valid_q, valid_d;
  logic [BAND_W-1:0]        band_q, band_d;
  logic signed [GAIN_W-1:0] gain_q, gain_d;

  // Next holding-register contents: clear on transfer, capture on load when idle.
  always_comb begin
    valid_d = valid_q;
    band_d  = band_q;
    gain_d  = gain_q;
    if (valid_q) begin
      if (i_ready) begin
        valid_d = 1'b0;
      end
    end else if (i_load) begin
      valid_d = 1'b1;
      band_d  = i_band;
      gain_d  = i_gain;
    end
  end

  // Holding register; reset drops any pending request immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      band_q  <= '0;
      gain_q  <= '0;
    end else begin
      valid_q <= valid_d;
      band_q  <= band_d;
      gain_q  <= gain_d;
    end
  end

  assign o_valid = valid_q;
  assign o_band  = band_q;
  assign o_gain  = gain_q;
  assign o_done  = valid_q & i_ready;

endmodule

// File: rtl/eq_param_ctrl.sv
// Button-driven control FSM for the N-band audio EQ: menu, per-band gain edit
// with cancel, offset edit, and a sequenced reset sweep. Gain updates reach
// the DSP through eq_write_port.
// Optional build macro EQ_LIVE_UPDATE_EN: each gain step (and a cancel) is
// also written to the DSP immediately; without it, writes happen only on
// commit and during the reset sweep.
module eq_param_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int N_BAND     = 7,
  parameter int GAIN_W     = 16,
  parameter int GAIN_MAX   = 12,
  parameter int GAIN_MIN   = -12,
  parameter int OFFSET_MAX = 3,
  parameter int OFFSET_W   = 3,
  localparam int BAND_W    = $clog2(N_BAND)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_select,
  input  logic                     i_back,
  input  logic                     i_up,
  input  logic                     i_down,
  input  logic                     i_init_done,
  output logic                     o_i2c_start,
  output logic [2:0]               o_state,
  output logic [1:0]               o_menu,
  output logic [BAND_W-1:0]        o_band,
  output logic signed [GAIN_W-1:0] o_gain,
  output logic [OFFSET_W-1:0]      o_offset,
  output logic                     o_wr_valid,
  output logic [BAND_W-1:0]        o_wr_band,
  output logic signed [GAIN_W-1:0] o_wr_gain,
  input  logic                     i_wr_ready,
  output logic                     o_dsp_reset
);

  localparam int SWEEP_W = $clog2(N_BAND + 1);

  state_t                   state_q, state_d;
  state_t                   ret_q, ret_d;
  menu_t                    menu_q, menu_d;
  logic [BAND_W-1:0]        band_q, band_d;
  logic [OFFSET_W-1:0]      offset_q, offset_d;
  logic signed [GAIN_W-1:0] backup_q, backup_d;
  logic [SWEEP_W-1:0]       sweep_q, sweep_d;
  logic                     dsp_reset_q, dsp_reset_d;
  logic signed [GAIN_W-1:0] gain_q [N_BAND];
  logic signed [GAIN_W-1:0] gain_d [N_BAND];

  logic signed [GAIN_W-1:0] cur_gain;
  logic signed [GAIN_W-1:0] step_gain;
  logic [BAND_W-1:0]        sweep_idx;
  logic                     wr_load;
  logic [BAND_W-1:0]        wr_band_in;
  logic signed [GAIN_W-1:0] wr_gain_in;
  logic                     wr_done;

  assign cur_gain  = gain_q[band_q];
  assign step_gain = GAIN_W'(gain_step(int'(cur_gain), i_up, GAIN_MIN, GAIN_MAX));
  assign sweep_idx = BAND_W'(sweep_q);

  // Next-state and register updates; buttons resolved back > select > up > down.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    menu_d      = menu_q;
    band_d      = band_q;
    offset_d    = offset_q;
    backup_d    = backup_q;
    sweep_d     = sweep_q;
    gain_d      = gain_q;
    dsp_reset_d = 1'b0;
    wr_load     = 1'b0;
    wr_band_in  = band_q;
    wr_gain_in  = cur_gain;

    case (state_q)
      S_INIT: begin
        if (i_init_done) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (!i_back && i_select) begin
          state_d = S_MENU;
          menu_d  = M_EQ;
        end
      end

      S_MENU: begin
        if (i_back) begin
          state_d = S_IDLE;
        end else if (i_select) begin
          case (menu_q)
            M_EQ: begin
              state_d = S_BAND_SEL;
              band_d  = '0;
            end
            M_OFFSET: state_d = S_SET_OFFSET;
            default: begin
              state_d = S_RESET_SWEEP;
              sweep_d = '0;
            end
          endcase
        end else if (i_up) begin
          if (menu_q != M_RESET) menu_d = menu_t'(menu_q + 2'd1);
        end else if (i_down) begin
          if (menu_q != M_EQ) menu_d = menu_t'(menu_q - 2'd1);
        end
      end

      S_BAND_SEL: begin
        if (i_back) begin
          state_d = S_MENU;
        end else if (i_select) begin
          state_d  = S_SET_GAIN;
          backup_d = cur_gain;
        end else if (i_up) begin
          if (band_q != BAND_W'(N_BAND - 1)) band_d = band_q + BAND_W'(1);
        end else if (i_down) begin
          if (band_q != '0) band_d = band_q - BAND_W'(1);
        end
      end

      S_SET_GAIN: begin
        if (i_back) begin
          // Cancel: restore the value captured on entry.
          gain_d[band_q] = backup_q;
          state_d        = S_BAND_SEL;
`ifdef EQ_LIVE_UPDATE_EN
          wr_load    = 1'b1;
          wr_gain_in = backup_q;
          ret_d      = S_BAND_SEL;
          state_d    = S_WRITE;
`endif
        end else if (i_select) begin
          wr_load = 1'b1;
          ret_d   = S_BAND_SEL;
          state_d = S_WRITE;
        end else if (i_up || i_down) begin
          gain_d[band_q] = step_gain;
`ifdef EQ_LIVE_UPDATE_EN
          if (step_gain != cur_gain) begin
            wr_load    = 1'b1;
            wr_gain_in = step_gain;
            ret_d      = S_SET_GAIN;
            state_d    = S_WRITE;
          end
`endif
        end
      end

      S_SET_OFFSET: begin
        if (i_back || i_select) begin
          state_d = S_MENU;
        end else if (i_up) begin
          if (offset_q != '0) offset_d = offset_q - OFFSET_W'(1);
        end else if (i_down) begin
          if (offset_q < OFFSET_W'(OFFSET_MAX)) offset_d = offset_q + OFFSET_W'(1);
        end
      end

      S_WRITE: begin
        // Buttons are deliberately ignored until the DSP takes the write.
        if (wr_done) state_d = ret_q;
      end

      S_RESET_SWEEP: begin
        if (sweep_q == SWEEP_W'(N_BAND)) begin
          dsp_reset_d = 1'b1;
          offset_d    = '0;
          state_d     = S_MENU;
        end else begin
          gain_d[sweep_idx] = '0;
          wr_load           = 1'b1;
          wr_band_in        = sweep_idx;
          wr_gain_in        = '0;
          sweep_d           = sweep_q + SWEEP_W'(1);
          ret_d             = S_RESET_SWEEP;
          state_d           = S_WRITE;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // Control and gain registers; reset aborts any edit, write or sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_INIT;
      ret_q       <= S_BAND_SEL;
      menu_q      <= M_EQ;
      band_q      <= '0;
      offset_q    <= '0;
      backup_q    <= '0;
      sweep_q     <= '0;
      dsp_reset_q <= 1'b0;
      gain_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      menu_q      <= menu_d;
      band_q      <= band_d;
      offset_q    <= offset_d;
      backup_q    <= backup_d;
      sweep_q     <= sweep_d;
      dsp_reset_q <= dsp_reset_d;
      gain_q      <= gain_d;
    end
  end

  eq_write_port #(
    .BAND_W (BAND_W),
    .GAIN_W (GAIN_W)
  ) u_wr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (wr_load),
    .i_band  (wr_band_in),
    .i_gain  (wr_gain_in),
    .i_ready (i_wr_ready),
    .o_valid (o_wr_valid),
    .o_band  (o_wr_band),
    .o_gain  (o_wr_gain),
    .o_done  (wr_done)
  );

  assign o_i2c_start = (state_q == S_INIT);
  assign o_state     = state_q;
  assign o_menu      = menu_q;
  assign o_band      = band_q;
  assign o_gain      = cur_gain;
  assign o_offset    = offset_q;
  assign o_dsp_reset = dsp_reset_q;

endmodule

// File: tb/tb_eq_param_ctrl.sv
// Bench for eq_param_ctrl: directed button sequences; expected DSP writes are
// queued as they are provoked and a monitor pops them on each handshake.
module tb_eq_param_ctrl;

  localparam int SEL = 0, BACK = 1, UP = 2, DN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0, back = 1'b0, up = 1'b0, dn = 1'b0;
  logic        init_done = 1'b0;
  logic        wr_ready = 1'b1;
  logic        i2c_start;
  logic [2:0]  state;
  logic [1:0]  menu;
  logic [2:0]  band;
  logic signed [15:0] gain;
  logic [2:0]  offset;
  logic        wr_valid;
  logic [2:0]  wr_band;
  logic signed [15:0] wr_gain;
  logic        dsp_reset;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  eq_param_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_select    (sel),
    .i_back      (back),
    .i_up        (up),
    .i_down      (dn),
    .i_init_done (init_done),
    .o_i2c_start (i2c_start),
    .o_state     (state),
    .o_menu      (menu),
    .o_band      (band),
    .o_gain      (gain),
    .o_offset    (offset),
    .o_wr_valid  (wr_valid),
    .o_wr_band   (wr_band),
    .o_wr_gain   (wr_gain),
    .i_wr_ready  (wr_ready),
    .o_dsp_reset (dsp_reset)
  );

  always #5 clk = ~clk;

  function automatic int pack(input int b, input int g);
    return (b << 16) | (g & 32'hFFFF);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      sel  = (b == SEL);
      back = (b == BACK);
      up   = (b == UP);
      dn   = (b == DN);
      tick();
      sel = 1'b0; back = 1'b0; up = 1'b0; dn = 1'b0;
    end
  endtask

  // Monitor: pops one expected write per handshake and checks request stability.
  initial begin
    logic       pv, px;
    int         pword;
    int         e;
    pv = 1'b0; px = 1'b0; pword = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv && !px) begin
          checks++;
          if (!wr_valid || pack(int'(wr_band), int'(wr_gain)) != pword) begin
            errors++;
            $display("FAIL wr_hold: got valid=%0d word=%0h expected valid=1 word=%0h",
                     wr_valid, pack(int'(wr_band), int'(wr_gain)), pword);
          end
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: got band=%0d gain=%0d expected no write",
                     wr_band, wr_gain);
          end else begin
            e = exp_q.pop_front();
            chk("wr_xfer", pack(int'(wr_band), int'(wr_gain)), e);
          end
        end
      end
      pv    = wr_valid && !rst;
      px    = wr_valid && wr_ready;
      pword = pack(int'(wr_band), int'(wr_gain));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset and codec init handshake
    repeat (3) tick();
    chk("rst_state", int'(state), 0);
    chk("rst_i2c", int'(i2c_start), 1);
    chk("rst_outs", int'({menu, band, offset, wr_valid, dsp_reset}), 0);
    chk("rst_gain", int'(gain), 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i2c_start && state == 3'd0) n++;
    end
    chk("init_wait", n, 10);
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("idle_state", int'(state), 1);
    chk("idle_i2c", int'(i2c_start), 0);

    // Band 3 to the upper gain limit and commit
    press(SEL, 1);
    chk("menu_state", int'(state), 2);
    press(DN, 1);
    chk("menu_sat0", int'(menu), 0);
    press(SEL, 1);
    chk("bandsel_state", int'(state), 3);
    press(UP, 3);
    chk("band3", int'(band), 3);
    press(SEL, 1);
    chk("setgain_state", int'(state), 4);
    press(UP, 20);
    chk("gain_sat_max", int'(gain), 12);
    exp_q.push_back(pack(3, 12));
    press(SEL, 1);
    chk("commit_valid", int'({state, wr_valid}), (6 << 1) | 1);
    tick();
    chk("after_write", int'({state, wr_valid}), 3 << 1);

    // Band 2 to -5, then an edit that is cancelled
    press(DN, 1);
    press(SEL, 1);
    chk("b2_gain0", int'(gain), 0);
    press(DN, 5);
    exp_q.push_back(pack(2, -5));
    press(SEL, 1);
    tick();
    chk("b2_commit", int'(gain), -5);
    press(SEL, 1);
    press(DN, 3);
    chk("b2_edit", int'(gain), -8);
    press(BACK, 1);
    chk("cancel_state", int'(state), 3);
    chk("cancel_gain", int'(gain), -5);

    // Back-pressured commit with buttons pressed while waiting
    wr_ready = 1'b0;
    press(SEL, 1);
    press(UP, 1);
    exp_q.push_back(pack(2, -4));
    press(SEL, 1);
    for (int i = 0; i < 5; i++) begin
      press(i % 4, 1);
      chk("stall_hold", int'({state, wr_valid, wr_band}) << 16 | (int'(wr_gain) & 32'hFFFF),
          ((6 << 4) | (1 << 3) | 2) << 16 | (-4 & 32'hFFFF));
    end
    wr_ready = 1'b1;
    tick();
    chk("stall_done", int'(state), 3);
    chk("stall_gain", int'(gain), -4);

    // Offset edit, limits and back+up in the same cycle
    press(BACK, 1);
    press(UP, 1);
    chk("menu_offset", int'(menu), 1);
    press(SEL, 1);
    chk("offset_state", int'(state), 5);
    press(DN, 5);
    chk("offset_sat", int'(offset), 3);
    press(UP, 1);
    chk("offset_2", int'(offset), 2);
    back = 1'b1;
    up   = 1'b1;
    tick();
    back = 1'b0;
    up   = 1'b0;
    chk("backup_prio", int'({state, offset}), (2 << 3) | 2);
    press(UP, 2);
    chk("menu_sat2", int'(menu), 2);

    // Reset sweep with a toggling ready
    for (int k = 0; k < 7; k++) exp_q.push_back(pack(k, 0));
    press(SEL, 1);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      wr_ready = (c % 3 != 1);
      tick();
      if (dsp_reset) n++;
    end
    wr_ready = 1'b1;
    chk("sweep_dsp_pulse", n, 1);
    chk("sweep_state", int'(state), 2);
    chk("sweep_offset", int'(offset), 0);
    chk("sweep_gain", int'(gain), 0);
    chk("sweep_q_empty", exp_q.size(), 0);

    // Reset asserted while a sweep write is pending
    press(SEL, 1);
    wr_ready = 1'b0;
    tick();
    chk("abort_pre", int'({state, wr_valid}), (6 << 1) | 1);
    rst = 1'b1;
    #1;
    chk("abort_valid", int'(wr_valid), 0);
    chk("abort_state", int'(state), 0);
    tick();
    tick();
    rst = 1'b0;
    wr_ready = 1'b1;
    tick();
    chk("abort_after", int'({i2c_start, band, menu}), 1 << 5);
    chk("abort_gain", int'(gain), 0);
    chk("end_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
